// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle shared by IF, MEM and the cache controller.
// slave = arbiter view, master = pipeline/cache-controller view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_freeze;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_freeze;
    logic [ADDR_W-1:0] down_addr;
    logic [DATA_W-1:0] down_wdata;
    logic              down_r_en;
    logic              down_w_en;
    logic [DATA_W-1:0] down_rdata;
    logic              down_freeze;

    modport slave (
        input  if_req, if_addr,
        input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
        input  down_rdata, down_freeze,
        output if_rdata, if_freeze,
        output mem_rdata, mem_freeze,
        output down_addr, down_wdata, down_r_en, down_w_en
    );

    modport master (
        output if_req, if_addr,
        output mem_r_en, mem_w_en, mem_addr, mem_wdata,
        output down_rdata, down_freeze,
        input  if_rdata, if_freeze,
        input  mem_rdata, mem_freeze,
        input  down_addr, down_wdata, down_r_en, down_w_en
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for the single cache-controller port, zero added latency.
// Optional IF anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 32,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus,
    output logic                   grant_mem,
    output logic                   rw_conflict
);

    if (MAX_MEM_STREAK < 1 || MAX_MEM_STREAK > 15) begin : g_bad_streak
        $error("MAX_MEM_STREAK out of range 1..15");
    end

    typedef enum logic {UNLOCKED, LOCKED} lock_e;

    lock_e             state, state_nx;
    logic              owner, owner_nx;
    logic [DATA_W-1:0] if_hold, mem_hold;
    logic              mem_act, mem_rd;
    logic              gnt_mem, gnt_if;
    logic              active, done;
    logic              starve;

    assign mem_act = bus.mem_r_en | bus.mem_w_en;
    // Both enables high is resolved as a write.
    assign mem_rd  = bus.mem_r_en & ~bus.mem_w_en;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] streak;

    assign starve = (streak >= 4'(MAX_MEM_STREAK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (!bus.if_req || (gnt_if && (done || state == UNLOCKED))) begin
            streak <= '0;
        end else if (gnt_mem && done && streak != 4'hF) begin
            streak <= streak + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        gnt_mem = 1'b0;
        gnt_if  = 1'b0;
        if (!rst) begin
            gnt_mem = 1'b0;
        end else if (state == LOCKED) begin
            gnt_mem = owner;
            gnt_if  = ~owner;
        end else if (bus.if_req && (starve || !mem_act)) begin
            gnt_if  = 1'b1;
        end else if (mem_act) begin
            gnt_mem = 1'b1;
        end
    end

    // A locked owner that drops its request is aborted, not served.
    assign active = gnt_mem ? mem_act : (gnt_if & bus.if_req);
    assign done   = active & ~bus.down_freeze;

    assign grant_mem = gnt_mem;

    always_comb begin
        bus.down_addr  = '0;
        bus.down_wdata = '0;
        bus.down_r_en  = 1'b0;
        bus.down_w_en  = 1'b0;
        if (gnt_mem) begin
            bus.down_addr  = bus.mem_addr;
            bus.down_wdata = bus.mem_wdata;
            bus.down_r_en  = mem_rd;
            bus.down_w_en  = bus.mem_w_en;
        end else if (gnt_if) begin
            bus.down_addr  = bus.if_addr;
            bus.down_r_en  = bus.if_req;
        end
    end

    assign bus.if_freeze  = rst & bus.if_req & (~gnt_if | bus.down_freeze);
    assign bus.mem_freeze = rst & mem_act & (~gnt_mem | bus.down_freeze);

    assign bus.if_rdata  = (gnt_if && done) ? bus.down_rdata : if_hold;
    assign bus.mem_rdata = (gnt_mem && done && mem_rd) ? bus.down_rdata
                                                       : mem_hold;

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        unique case (state)
            UNLOCKED: begin
                if ((gnt_if || gnt_mem) && bus.down_freeze) begin
                    state_nx = LOCKED;
                    owner_nx = gnt_mem;
                end
            end
            LOCKED: begin
                if (!active || !bus.down_freeze) begin
                    state_nx = UNLOCKED;
                end
            end
            default: state_nx = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNLOCKED;
            owner <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_hold     <= '0;
            mem_hold    <= '0;
            rw_conflict <= 1'b0;
        end else begin
            if (gnt_if && done) begin
                if_hold <= bus.down_rdata;
            end
            if (gnt_mem && done && mem_rd) begin
                mem_hold <= bus.down_rdata;
            end
            if (bus.mem_r_en && bus.mem_w_en) begin
                rw_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, hit, miss lock, abort,
// rw conflict and the IF streak pattern.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic grant_mem;
    logic rw_conflict;
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_port_arbiter_if #(.ADDR_W(18), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(18), .DATA_W(32), .MAX_MEM_STREAK(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant_mem  (grant_mem),
        .rw_conflict(rw_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req      = 1'b0;
        bus.if_addr     = '0;
        bus.mem_r_en    = 1'b0;
        bus.mem_w_en    = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.down_rdata  = '0;
        bus.down_freeze = 1'b0;
    endtask

    initial begin
        logic exp_gm;
        rst = 1'b0;
        idle();
        #2;
        chk("rst_r_en", bus.down_r_en, 0);
        chk("rst_w_en", bus.down_w_en, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_mem_rdata", bus.mem_rdata, 0);
        chk("rst_conflict", rw_conflict, 0);
        step();
        step();
        rst = 1'b1;

        // Hit with both requesting: MEM wins, IF served next cycle
        bus.mem_r_en   = 1'b1;
        bus.mem_addr   = 18'h00010;
        bus.if_req     = 1'b1;
        bus.if_addr    = 18'h00100;
        bus.down_rdata = 32'hDEADBEEF;
        #2;
        chk("hit_addr", bus.down_addr, 32'h10);
        chk("hit_r_en", bus.down_r_en, 1);
        chk("hit_mem_rdata", bus.mem_rdata, 32'hDEADBEEF);
        chk("hit_mem_frz", bus.mem_freeze, 0);
        chk("hit_if_frz", bus.if_freeze, 1);
        chk("hit_gm", grant_mem, 1);
        step();
        bus.mem_r_en   = 1'b0;
        bus.down_rdata = 32'hCAFEF00D;
        #2;
        chk("if_addr", bus.down_addr, 32'h100);
        chk("if_rdata", bus.if_rdata, 32'hCAFEF00D);
        chk("if_frz", bus.if_freeze, 0);
        chk("if_gm", grant_mem, 0);
        chk("mem_hold", bus.mem_rdata, 32'hDEADBEEF);
        step();
        bus.if_req = 1'b0;

        // Miss lock on IF while MEM write arrives
        bus.if_req      = 1'b1;
        bus.if_addr     = 18'h00200;
        bus.down_freeze = 1'b1;
        #2;
        chk("miss_addr1", bus.down_addr, 32'h200);
        chk("miss_if_frz", bus.if_freeze, 1);
        step();
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = 18'h00300;
        bus.mem_wdata = 32'h00000055;
        #2;
        chk("miss_addr2", bus.down_addr, 32'h200);
        chk("miss_w_en2", bus.down_w_en, 0);
        chk("miss_mem_frz2", bus.mem_freeze, 1);
        chk("miss_gm2", grant_mem, 0);
        step();
        #2;
        chk("miss_addr3", bus.down_addr, 32'h200);
        chk("miss_mem_frz3", bus.mem_freeze, 1);
        step();
        bus.down_freeze = 1'b0;
        bus.down_rdata  = 32'h12345678;
        #2;
        chk("miss_done_rdata", bus.if_rdata, 32'h12345678);
        chk("miss_done_if_frz", bus.if_freeze, 0);
        chk("miss_done_addr", bus.down_addr, 32'h200);
        chk("miss_done_mem_frz", bus.mem_freeze, 1);
        step();
        bus.if_req = 1'b0;
        #2;
        chk("nb_addr", bus.down_addr, 32'h300);
        chk("nb_w_en", bus.down_w_en, 1);
        chk("nb_wdata", bus.down_wdata, 32'h55);
        chk("nb_mem_frz", bus.mem_freeze, 0);
        chk("nb_gm", grant_mem, 1);
        chk("nb_if_hold", bus.if_rdata, 32'h12345678);
        step();
        bus.mem_w_en = 1'b0;

        // Abort of a locked MEM read
        bus.mem_r_en    = 1'b1;
        bus.mem_addr    = 18'h00040;
        bus.down_freeze = 1'b1;
        bus.down_rdata  = 32'h0BADF00D;
        #2;
        chk("ab_mem_frz", bus.mem_freeze, 1);
        chk("ab_r_en", bus.down_r_en, 1);
        step();
        bus.mem_r_en = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 18'h00500;
        #2;
        chk("ab_r_en_drop", bus.down_r_en, 0);
        chk("ab_gm_locked", grant_mem, 1);
        chk("ab_mem_hold", bus.mem_rdata, 32'hDEADBEEF);
        chk("ab_if_frz", bus.if_freeze, 1);
        step();
        bus.down_freeze = 1'b0;
        bus.down_rdata  = 32'h0000A0A0;
        #2;
        chk("ab_unlock_gm", grant_mem, 0);
        chk("ab_unlock_addr", bus.down_addr, 32'h500);
        chk("ab_unlock_rdata", bus.if_rdata, 32'hA0A0);
        step();
        bus.if_req = 1'b0;

        // Read+write together resolves as write, sticky flag
        bus.mem_r_en  = 1'b1;
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = 18'h00060;
        bus.mem_wdata = 32'h0000A5A5;
        #2;
        chk("rw_w_en", bus.down_w_en, 1);
        chk("rw_r_en", bus.down_r_en, 0);
        chk("rw_flag_pre", rw_conflict, 0);
        step();
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        chk("rw_flag_set", rw_conflict, 1);
        step();
        step();
        chk("rw_flag_sticky", rw_conflict, 1);

        // Reset in the middle of a locked MEM write
        bus.mem_w_en    = 1'b1;
        bus.mem_addr    = 18'h00070;
        bus.down_freeze = 1'b1;
        step();
        chk("rl_w_en", bus.down_w_en, 1);
        rst = 1'b0;
        #1;
        chk("rl_w_en_rst", bus.down_w_en, 0);
        chk("rl_mem_frz", bus.mem_freeze, 0);
        chk("rl_if_frz", bus.if_freeze, 0);
        chk("rl_conflict", rw_conflict, 0);
        chk("rl_mem_rdata", bus.mem_rdata, 0);
        chk("rl_gm", grant_mem, 0);
        step();
        rst          = 1'b1;
        bus.mem_w_en = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 18'h00080;
        #2;
        chk("rl_unlocked_gm", grant_mem, 0);
        chk("rl_unlocked_r_en", bus.down_r_en, 1);
        chk("rl_unlocked_frz", bus.if_freeze, 1);
        step();
        idle();
        step();

        // Continuous MEM hits with IF waiting
        bus.if_req   = 1'b1;
        bus.if_addr  = 18'h00900;
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 18'h00A00;
        for (int i = 0; i < 10; i++) begin
            #2;
`ifdef ARB_STARVE_GUARD_EN
            exp_gm = (i % 5) != 4;
`else
            exp_gm = 1'b1;
`endif
            chk($sformatf("streak_gm%0d", i), grant_mem, exp_gm);
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
